// File: rtl/risc_boot_loader.sv
// Framed byte-stream program loader: assembles big-endian instructions into the
// instruction memory, verifies the checksum and only then releases the core.
module risc_boot_loader #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [8:0]  words_loaded
);
    localparam int unsigned CNT_W  = 16;
    localparam logic [7:0]  HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         hi_q, hi_d;
    logic               imem_we_q, imem_we_d;
    logic [7:0]         imem_addr_q, imem_addr_d;
    logic [15:0]        imem_wdata_q, imem_wdata_d;
    logic               core_reset_q, core_reset_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [8:0]         words_q, words_d;
    logic               xfer;

    // Byte acceptance depends on state only, so there is no bubble between bytes.
    assign in_ready = (state_q != S_RUN) && (state_q != S_ERROR);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        idle_d       = idle_q;
        len_d        = len_q;
        sum_d        = sum_q;
        hi_d         = hi_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        words_d      = words_q;

        case (state_q)
            S_IDLE: begin
                if (xfer && in_data == HEADER) begin
                    state_d = S_LEN;
                    idle_d  = '0;
                end
            end
            S_LEN, S_HI, S_LO, S_CHECK: begin
                if (xfer) begin
                    idle_d = '0;
                    case (state_q)
                        S_LEN: begin
                            if (in_data == 8'h00) begin
                                state_d    = S_ERROR;
                                err_d      = 1'b1;
                                err_code_d = 2'b11;
                            end else begin
                                len_d   = in_data;
                                sum_d   = in_data;
                                words_d = '0;
                                state_d = S_HI;
                            end
                        end
                        S_HI: begin
                            hi_d    = in_data;
                            sum_d   = sum_q + in_data;
                            state_d = S_LO;
                        end
                        S_LO: begin
                            sum_d        = sum_q + in_data;
                            imem_we_d    = 1'b1;
                            imem_addr_d  = words_q[7:0];
                            imem_wdata_d = {hi_q, in_data};
                            words_d      = words_q + 9'd1;
                            state_d      = (words_q + 9'd1 == {1'b0, len_q}) ? S_CHECK : S_HI;
                        end
                        default: begin
                            if (in_data == sum_q) begin
                                state_d      = S_RUN;
                                core_reset_d = 1'b0;
                                done_d       = 1'b1;
                            end else begin
                                state_d    = S_ERROR;
                                err_d      = 1'b1;
                                err_code_d = 2'b01;
                            end
                        end
                    endcase
                end else begin
                    // A transfer on the would-be timeout cycle wins, handled above.
                    idle_d = idle_q + CNT_W'(1);
                    if (idle_d == CNT_W'(TIMEOUT)) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idle_q       <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            hi_q         <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            hi_q         <= hi_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            words_q      <= words_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_risc_boot_loader.sv
// Bench for risc_boot_loader: frame-level reference model feeds a write
// scoreboard that a negedge monitor drains; frame outcomes are checked per frame.
module tb_risc_boot_loader;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  words_loaded;

    risc_boot_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done),
        .err(err), .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int         total = 0;
    int         bad   = 0;
    wr_t        sb_q[$];
    wr_t        mon_e;
    logic [7:0] frm[$];
    int         exp_code;
    int         exp_words;
    int         exp_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h want no write",
                             imem_addr, imem_wdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("imem_write", {imem_addr, imem_wdata}, {mon_e.a, mon_e.d});
                end
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            in_data = 8'($urandom);
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_state",
            {in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, err, err_code, words_loaded},
            {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 9'h000});
    endtask

    task automatic send_byte(input logic [7:0] b);
        chk("in_ready_before_byte", in_ready, 1'b1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference: parse the frame positionally; stop = bytes sent before a stall (-1 = all).
    task automatic model(input int stop);
        int h, n, avail, s;
        avail = (stop < 0) ? frm.size() : stop;
        h = 0;
        while (frm[h] != 8'hA5) h++;
        n         = int'(frm[h+1]);
        exp_words = 0;
        exp_done  = 0;
        if (n == 0 && avail >= h + 2) begin
            exp_code = 3;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (h + 3 + 2*i < avail) begin
                    sb_q.push_back({8'(i), frm[h+2+2*i], frm[h+3+2*i]});
                    exp_words++;
                end
            end
            if (avail == frm.size()) begin
                s = n;
                for (int i = 0; i < 2*n; i++) s += int'(frm[h+2+i]);
                exp_code = ((s % 256) == int'(frm[h+2+2*n])) ? 0 : 1;
                exp_done = (exp_code == 0) ? 1 : 0;
            end else begin
                exp_code = 2;
            end
        end
    endtask

    task automatic run_frame(input int stop, input int maxgap);
        int avail;
        model(stop);
        avail = (stop < 0) ? frm.size() : stop;
        for (int i = 0; i < avail; i++) begin
            send_byte(frm[i]);
            if (i < avail - 1 && maxgap > 0) idle($urandom_range(0, maxgap));
        end
        if (stop >= 0) begin
            idle(TO - 1);
            chk("no_early_timeout", err, 1'b0);
            idle(1);
        end
        chk("frame_status",
            {core_reset, done, err, err_code, words_loaded, in_ready},
            {~1'(exp_done), 1'(exp_done), 1'(exp_code != 0), 2'(exp_code), 9'(exp_words), 1'b0});
        idle(2);
        chk("writes_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic build(input int n, input bit bad_ck, input int garbage);
        logic [7:0] s, b;
        frm.delete();
        for (int i = 0; i < garbage; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            frm.push_back(b);
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(n));
        s = 8'(n);
        for (int i = 0; i < 2*n; i++) begin
            b = 8'($urandom);
            frm.push_back(b);
            s = s + b;
        end
        if (bad_ck) s = s + 8'($urandom_range(1, 255));
        frm.push_back(s);
    endtask

    initial begin
        int n, g, stop;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);

        do_reset();
        frm = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h14, 8'h56, 8'h90};
        run_frame(-1, 0);

        do_reset();
        frm = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h14, 8'h56, 8'h91};
        run_frame(-1, 0);

        do_reset();
        frm = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h50, 8'h00, 8'h51};
        run_frame(-1, 0);

        do_reset();
        frm = '{8'hA5, 8'h00};
        run_frame(-1, 0);

        do_reset();
        frm = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
        run_frame(3, 0);

        // Gaps of TO-1 idle cycles must never time out.
        do_reset();
        build(4, 1'b0, 0);
        model(-1);
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i]);
            if (i < frm.size() - 1) idle(TO - 1);
        end
        chk("max_gap_done", {done, err}, {1'b1, 1'b0});
        idle(2);

        do_reset();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        do_reset();
        build(255, 1'b0, 0);
        run_frame(-1, 0);

        for (int it = 0; it < 30; it++) begin
            do_reset();
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
            g = $urandom_range(0, 3);
            build(n, $urandom_range(0, 3) == 0, g);
            if (n == 0) begin
                frm.pop_back();
                run_frame(-1, 3);
            end else if ($urandom_range(0, 4) == 0) begin
                stop = $urandom_range(g + 1, frm.size() - 1);
                run_frame(stop, TO - 1);
            end else begin
                run_frame(-1, TO - 1);
            end
        end

        idle(3);
        chk("scoreboard_empty_end", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
